// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  localparam u32 RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: issues one I-side request at a time, delivers the
// returned word to F2, buffers it across stalls and discards stale responses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  u1  clk,
  input  u1  reset,
  input  u1  stallF,
  input  u1  redirect_valid,
  input  u32 redirect_pc,
  output u1  ireq_valid,
  output u32 ireq_addr,
  input  u1  ireq_addr_ok,
  input  u1  iresp_data_ok,
  input  u32 iresp_data,
  output u1  i_wait,
  output u1  out_valid,
  output u32 out_pc,
  output u32 out_instr,
  output u1  out_adel
);

  fetch_state_t state_q, state_d;
  u32           pc_q, pc_d;
  u32           buf_instr_q, buf_instr_d;
  u1            buf_adel_q, buf_adel_d;

  u1  aligned;
  u1  deliver;
  u32 del_instr;
  u1  del_adel;

  assign aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_adel_d  = buf_adel_q;
    ireq_valid  = 1'b0;
    ireq_addr   = pc_q;
    deliver     = 1'b0;
    del_instr   = '0;
    del_adel    = 1'b0;

    unique case (state_q)
      REQ: begin
        ireq_valid = aligned;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = (aligned && ireq_addr_ok) ? DISCARD : REQ;
        end else if (aligned) begin
          if (ireq_addr_ok) state_d = WAIT;
        end else begin
          deliver  = 1'b1;
          del_adel = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = iresp_data_ok ? REQ : DISCARD;
        end else if (iresp_data_ok) begin
          deliver   = 1'b1;
          del_instr = iresp_data;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (iresp_data_ok) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else begin
          deliver   = 1'b1;
          del_instr = buf_instr_q;
          del_adel  = buf_adel_q;
        end
      end
      default: state_d = REQ;
    endcase

    // A delivery from REQ, WAIT or HOLD shares one advance/hold decision.
    if (deliver) begin
      if (stallF) begin
        buf_instr_d = del_instr;
        buf_adel_d  = del_adel;
        state_d     = HOLD;
      end else begin
        pc_d    = pc_q + 32'd4;
        state_d = REQ;
      end
    end

    out_valid = deliver;
    out_pc    = pc_q;
    out_instr = del_instr;
    out_adel  = del_adel;

    if (reset) begin
      ireq_valid = 1'b0;
      out_valid  = 1'b0;
      out_instr  = '0;
      out_adel   = 1'b0;
    end

    i_wait = (state_q == HOLD) ? 1'b0 : ~out_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      buf_instr_q <= '0;
      buf_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_adel_q  <= buf_adel_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with queued expected requests and deliveries.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        i_wait;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } deliv_t;

  deliv_t      exp_out[$];
  logic [31:0] exp_req[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .stallF(stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .ireq_addr_ok(ireq_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .i_wait(i_wait),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_adel(out_adel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic adel);
    deliv_t d;
    d.pc = pc;
    d.instr = instr;
    d.adel = adel;
    exp_out.push_back(d);
  endtask

  // Monitor: every delivery and every accepted request must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %h instr %h, expected no delivery (t=%0t)", out_pc, out_instr, $time);
        end else begin
          deliv_t e;
          e = exp_out.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_adel", {31'd0, out_adel}, {31'd0, e.adel});
        end
      end
      if (ireq_valid && ireq_addr_ok) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h, expected no request (t=%0t)", ireq_addr, $time);
        end else begin
          chk("req_addr", ireq_addr, exp_req.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stallF = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ireq_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
    next();
    probe();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_adel", {31'd0, out_adel}, 32'd0);
    next();
    reset = 1'b0;

    // Basic fetch from the reset vector.
    ireq_addr_ok = 1'b1; exp_req.push_back(32'hBFC0_0000);
    probe();
    chk("first_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    chk("first_ireq_addr", ireq_addr, 32'hBFC0_0000);
    next(); ireq_addr_ok = 1'b0;
    probe(); chk("wait_i_wait", {31'd0, i_wait}, 32'd1);
    next(); iresp_data_ok = 1'b1; iresp_data = 32'h2402_0001;
    push_out(32'hBFC0_0000, 32'h2402_0001, 1'b0);
    next(); iresp_data_ok = 1'b0;
    probe(); chk("seq_addr", ireq_addr, 32'hBFC0_0004);

    // Delivery under a three-cycle stall, then release.
    ireq_addr_ok = 1'b1; exp_req.push_back(32'hBFC0_0004);
    next(); ireq_addr_ok = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'h8C08_0010; stallF = 1'b1;
    push_out(32'hBFC0_0004, 32'h8C08_0010, 1'b0);
    next(); iresp_data_ok = 1'b0; iresp_data = 32'hFFFF_FFFF;
    push_out(32'hBFC0_0004, 32'h8C08_0010, 1'b0);
    probe();
    chk("hold_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    chk("hold_i_wait", {31'd0, i_wait}, 32'd0);
    next(); push_out(32'hBFC0_0004, 32'h8C08_0010, 1'b0);
    next(); stallF = 1'b0; push_out(32'hBFC0_0004, 32'h8C08_0010, 1'b0);
    next();
    probe(); chk("post_stall_addr", ireq_addr, 32'hBFC0_0008);

    // Redirect while waiting; stale response four cycles later.
    ireq_addr_ok = 1'b1; exp_req.push_back(32'hBFC0_0008);
    next(); ireq_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0180;
    probe(); chk("redir_wait_i_wait", {31'd0, i_wait}, 32'd1);
    next(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe();
      chk("discard_i_wait", {31'd0, i_wait}, 32'd1);
      chk("discard_ireq_valid", {31'd0, ireq_valid}, 32'd0);
      next();
    end
    iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
    probe();
    chk("stale_i_wait", {31'd0, i_wait}, 32'd1);
    chk("stale_out_valid", {31'd0, out_valid}, 32'd0);
    next(); iresp_data_ok = 1'b0;
    probe(); chk("redir_addr", ireq_addr, 32'h8000_0180);

    // Redirect coinciding with request acceptance.
    ireq_addr_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    exp_req.push_back(32'h8000_0180);
    probe(); chk("redir_req_out_valid", {31'd0, out_valid}, 32'd0);
    next(); ireq_addr_ok = 1'b0; redirect_valid = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
    probe();
    chk("discard2_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    chk("discard2_i_wait", {31'd0, i_wait}, 32'd1);
    next(); iresp_data_ok = 1'b0;
    ireq_addr_ok = 1'b1; exp_req.push_back(32'h8000_0200);
    next(); ireq_addr_ok = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'h1111_2222;
    push_out(32'h8000_0200, 32'h1111_2222, 1'b0);
    next(); iresp_data_ok = 1'b0;
    probe(); chk("after_discard_addr", ireq_addr, 32'h8000_0204);

    // Redirect to a misaligned PC, held by stall, then redirected from HOLD.
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0002;
    next(); redirect_valid = 1'b0; stallF = 1'b1;
    push_out(32'h0040_0002, 32'h0000_0000, 1'b1);
    probe(); chk("adel_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    next(); push_out(32'h0040_0002, 32'h0000_0000, 1'b1);
    next(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    probe();
    chk("hold_redir_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_redir_i_wait", {31'd0, i_wait}, 32'd0);
    next(); redirect_valid = 1'b0; stallF = 1'b0;
    ireq_addr_ok = 1'b1; exp_req.push_back(32'hFFFF_FFFC);
    next(); ireq_addr_ok = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'h3C1D_8000;
    push_out(32'hFFFF_FFFC, 32'h3C1D_8000, 1'b0);
    next(); iresp_data_ok = 1'b0;
    probe(); chk("wrap_addr", ireq_addr, 32'h0000_0000);

    // Redirect in the same cycle as the response: word dropped.
    ireq_addr_ok = 1'b1; exp_req.push_back(32'h0000_0000);
    next(); ireq_addr_ok = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'h1234_5678;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    probe(); chk("redir_data_out_valid", {31'd0, out_valid}, 32'd0);
    next(); iresp_data_ok = 1'b0; redirect_valid = 1'b0;
    probe(); chk("redir_data_addr", ireq_addr, 32'h0000_0100);

    // Reset while waiting drops the in-flight response.
    ireq_addr_ok = 1'b1; exp_req.push_back(32'h0000_0100);
    next(); ireq_addr_ok = 1'b0; reset = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'hCAFE_F00D;
    probe();
    chk("rst_wait_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wait_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    next(); reset = 1'b0; iresp_data_ok = 1'b0;
    probe();
    chk("rst_wait_ireq_valid2", {31'd0, ireq_valid}, 32'd1);
    chk("rst_wait_addr", ireq_addr, 32'hBFC0_0000);
    next();
    next();
    probe();
    chk("out_queue_empty", exp_out.size(), 32'd0);
    chk("req_queue_empty", exp_req.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
